soc_node_id_remap: RTL and testbench



---
 rtl/soc_node_pkg.sv | 9 +
 rtl/axi_bus.sv | 91 +++++++++
 rtl/soc_node_id_remap_table.sv | 100 ++++++++++
 rtl/soc_node_id_remap.sv | 130 +++++++++++++
 tb/tb_soc_node_id_remap.sv | 374 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/soc_node_pkg.sv
// Shared helpers for the SoC-side node logic.
// The ID remap tables size themselves from the narrow output ID width.
package soc_node_pkg;

    function automatic int unsigned axi_iw_remap(input int unsigned iw_mst);
        return 32'd1 << iw_mst;
    endfunction

endpackage

// File: rtl/axi_bus.sv
// Generic AXI4+ATOP bus bundle carrying one master/slave link.
// ID, address, data and user widths are set per instance.
interface AXI_BUS #(
    parameter int unsigned AXI_ADDR_WIDTH = 32,
    parameter int unsigned AXI_DATA_WIDTH = 64,
    parameter int unsigned AXI_ID_WIDTH   = 8,
    parameter int unsigned AXI_USER_WIDTH = 6
);
    localparam int unsigned AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8;

    logic [AXI_ID_WIDTH-1:0]   aw_id;
    logic [AXI_ADDR_WIDTH-1:0] aw_addr;
    logic [7:0]                aw_len;
    logic [2:0]                aw_size;
    logic [1:0]                aw_burst;
    logic                      aw_lock;
    logic [3:0]                aw_cache;
    logic [2:0]                aw_prot;
    logic [3:0]                aw_qos;
    logic [3:0]                aw_region;
    logic [5:0]                aw_atop;
    logic [AXI_USER_WIDTH-1:0] aw_user;
    logic                      aw_valid;
    logic                      aw_ready;

    logic [AXI_DATA_WIDTH-1:0] w_data;
    logic [AXI_STRB_WIDTH-1:0] w_strb;
    logic                      w_last;
    logic [AXI_USER_WIDTH-1:0] w_user;
    logic                      w_valid;
    logic                      w_ready;

    logic [AXI_ID_WIDTH-1:0]   b_id;
    logic [1:0]                b_resp;
    logic [AXI_USER_WIDTH-1:0] b_user;
    logic                      b_valid;
    logic                      b_ready;

    logic [AXI_ID_WIDTH-1:0]   ar_id;
    logic [AXI_ADDR_WIDTH-1:0] ar_addr;
    logic [7:0]                ar_len;
    logic [2:0]                ar_size;
    logic [1:0]                ar_burst;
    logic                      ar_lock;
    logic [3:0]                ar_cache;
    logic [2:0]                ar_prot;
    logic [3:0]                ar_qos;
    logic [3:0]                ar_region;
    logic [AXI_USER_WIDTH-1:0] ar_user;
    logic                      ar_valid;
    logic                      ar_ready;

    logic [AXI_ID_WIDTH-1:0]   r_id;
    logic [AXI_DATA_WIDTH-1:0] r_data;
    logic [1:0]                r_resp;
    logic                      r_last;
    logic [AXI_USER_WIDTH-1:0] r_user;
    logic                      r_valid;
    logic                      r_ready;

    modport Master (
        output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
               aw_qos, aw_region, aw_atop, aw_user, aw_valid,
        input  aw_ready,
        output w_data, w_strb, w_last, w_user, w_valid,
        input  w_ready,
        input  b_id, b_resp, b_user, b_valid,
        output b_ready,
        output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
               ar_qos, ar_region, ar_user, ar_valid,
        input  ar_ready,
        input  r_id, r_data, r_resp, r_last, r_user, r_valid,
        output r_ready
    );

    modport Slave (
        input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
               aw_qos, aw_region, aw_atop, aw_user, aw_valid,
        output aw_ready,
        input  w_data, w_strb, w_last, w_user, w_valid,
        output w_ready,
        output b_id, b_resp, b_user, b_valid,
        input  b_ready,
        input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
               ar_qos, ar_region, ar_user, ar_valid,
        output ar_ready,
        output r_id, r_data, r_resp, r_last, r_user, r_valid,
        input  r_ready
    );

endinterface

// File: rtl/soc_node_id_remap_table.sv
// One direction of the ID remapper: wide-ID to table-index lookup with
// per-entry outstanding counters, plus index to original-ID restore on responses.
module soc_node_id_remap_table
    import soc_node_pkg::*;
#(
    parameter int unsigned IW_IN    = 8,
    parameter int unsigned IW_OUT   = 4,
    parameter int unsigned MAX_TXNS = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              req_valid,
    input  logic [IW_IN-1:0]  req_id,
    input  logic              req_hsk,
    input  logic              rsp_hsk,
    input  logic [IW_OUT-1:0] rsp_idx,
    output logic              req_gnt,
    output logic [IW_OUT-1:0] req_idx,
    output logic [IW_IN-1:0]  rsp_orig_id
);
    localparam int unsigned DEPTH = axi_iw_remap(IW_OUT);
    localparam int unsigned CNT_W = $clog2(MAX_TXNS + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_TXNS);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef struct packed {
        logic             valid;
        logic [IW_IN-1:0] orig_id;
        logic [CNT_W-1:0] cnt;
    } entry_t;

    entry_t tbl [DEPTH];

    logic              hit;
    logic              free_avail;
    logic [IW_OUT-1:0] hit_idx;
    logic [IW_OUT-1:0] free_idx;
    logic [DEPTH-1:0]  inc_vec;
    logic [DEPTH-1:0]  dec_vec;

    // Descending scan so the lowest-index free entry wins; a hit is unique anyway.
    always_comb begin
        hit        = 1'b0;
        hit_idx    = '0;
        free_avail = 1'b0;
        free_idx   = '0;
        for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
            if (tbl[i].valid && (tbl[i].orig_id == req_id)) begin
                hit     = 1'b1;
                hit_idx = IW_OUT'(i);
            end
            if (!tbl[i].valid) begin
                free_avail = 1'b1;
                free_idx   = IW_OUT'(i);
            end
        end
    end

    assign req_idx     = hit ? hit_idx : free_idx;
    assign req_gnt     = req_valid && (hit ? (tbl[hit_idx].cnt < CNT_MAX) : free_avail);
    assign rsp_orig_id = tbl[rsp_idx].orig_id;

    always_comb begin
        inc_vec = '0;
        dec_vec = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            inc_vec[i] = req_hsk && (req_idx == IW_OUT'(i));
            dec_vec[i] = rsp_hsk && (rsp_idx == IW_OUT'(i));
        end
    end

    // An entry draining to zero stays valid until the edge, so a same-cycle
    // allocation can never land on it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                tbl[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (inc_vec[i] && !tbl[i].valid) begin
                    tbl[i].valid   <= 1'b1;
                    tbl[i].orig_id <= req_id;
                    tbl[i].cnt     <= CNT_ONE;
                end else if (inc_vec[i] && !dec_vec[i]) begin
                    tbl[i].cnt <= tbl[i].cnt + CNT_ONE;
                end else if (dec_vec[i] && !inc_vec[i]) begin
                    tbl[i].cnt <= tbl[i].cnt - CNT_ONE;
                    if (tbl[i].cnt == CNT_ONE) begin
                        tbl[i].valid <= 1'b0;
                    end
                end
            end
        end
    end

    rsp_targets_live_entry: assert property (@(posedge clk_i) disable iff (!rst_ni)
        rsp_hsk |-> (tbl[rsp_idx].valid && (tbl[rsp_idx].cnt != '0)));

endmodule

// File: rtl/soc_node_id_remap.sv
// Compresses crossbar-widened AXI IDs to the narrow SoC ID width and restores
// them on B/R, using independent write and read remap tables.
module soc_node_id_remap #(
    parameter int unsigned AXI_AW          = 32,
    parameter int unsigned AXI_DW          = 64,
    parameter int unsigned AXI_UW          = 6,
    parameter int unsigned AXI_IW_SLV      = 8,
    parameter int unsigned AXI_IW_MST      = 4,
    parameter int unsigned MAX_TXNS_PER_ID = 4
) (
    input logic   clk_i,
    input logic   rst_ni,
    AXI_BUS.Slave  slv,
    AXI_BUS.Master mst
);
    logic                  aw_gnt;
    logic                  ar_gnt;
    logic                  aw_hsk;
    logic                  ar_hsk;
    logic                  b_hsk;
    logic                  r_last_hsk;
    logic [AXI_IW_MST-1:0] aw_idx;
    logic [AXI_IW_MST-1:0] ar_idx;
    logic [AXI_IW_SLV-1:0] b_orig_id;
    logic [AXI_IW_SLV-1:0] r_orig_id;

    logic [AXI_AW-1:0] aw_addr;
    logic [AXI_AW-1:0] ar_addr;
    logic [AXI_DW-1:0] w_data;
    logic [AXI_DW-1:0] r_data;
    logic [AXI_UW-1:0] aw_user;
    logic [AXI_UW-1:0] ar_user;

    assign aw_hsk     = mst.aw_valid & mst.aw_ready;
    assign ar_hsk     = mst.ar_valid & mst.ar_ready;
    assign b_hsk      = slv.b_valid & slv.b_ready;
    assign r_last_hsk = slv.r_valid & slv.r_ready & slv.r_last;

    soc_node_id_remap_table #(
        .IW_IN   (AXI_IW_SLV),
        .IW_OUT  (AXI_IW_MST),
        .MAX_TXNS(MAX_TXNS_PER_ID)
    ) i_wr_table (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .req_valid  (slv.aw_valid),
        .req_id     (slv.aw_id),
        .req_hsk    (aw_hsk),
        .rsp_hsk    (b_hsk),
        .rsp_idx    (mst.b_id),
        .req_gnt    (aw_gnt),
        .req_idx    (aw_idx),
        .rsp_orig_id(b_orig_id)
    );

    soc_node_id_remap_table #(
        .IW_IN   (AXI_IW_SLV),
        .IW_OUT  (AXI_IW_MST),
        .MAX_TXNS(MAX_TXNS_PER_ID)
    ) i_rd_table (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .req_valid  (slv.ar_valid),
        .req_id     (slv.ar_id),
        .req_hsk    (ar_hsk),
        .rsp_hsk    (r_last_hsk),
        .rsp_idx    (mst.r_id),
        .req_gnt    (ar_gnt),
        .req_idx    (ar_idx),
        .rsp_orig_id(r_orig_id)
    );

    // A stalled request is hidden on both sides; gnt already includes the input valid.
    assign mst.aw_valid  = aw_gnt;
    assign slv.aw_ready  = mst.aw_ready & aw_gnt;
    assign mst.aw_id     = aw_idx;
    assign aw_addr       = slv.aw_addr;
    assign aw_user       = slv.aw_user;
    assign mst.aw_addr   = aw_addr;
    assign mst.aw_len    = slv.aw_len;
    assign mst.aw_size   = slv.aw_size;
    assign mst.aw_burst  = slv.aw_burst;
    assign mst.aw_lock   = slv.aw_lock;
    assign mst.aw_cache  = slv.aw_cache;
    assign mst.aw_prot   = slv.aw_prot;
    assign mst.aw_qos    = slv.aw_qos;
    assign mst.aw_region = slv.aw_region;
    assign mst.aw_atop   = slv.aw_atop;
    assign mst.aw_user   = aw_user;

    assign w_data        = slv.w_data;
    assign mst.w_data    = w_data;
    assign mst.w_strb    = slv.w_strb;
    assign mst.w_last    = slv.w_last;
    assign mst.w_user    = slv.w_user;
    assign mst.w_valid   = slv.w_valid;
    assign slv.w_ready   = mst.w_ready & slv.w_valid;

    assign slv.b_id      = b_orig_id;
    assign slv.b_resp    = mst.b_resp;
    assign slv.b_user    = mst.b_user;
    assign slv.b_valid   = mst.b_valid;
    assign mst.b_ready   = slv.b_ready & mst.b_valid;

    assign mst.ar_valid  = ar_gnt;
    assign slv.ar_ready  = mst.ar_ready & ar_gnt;
    assign mst.ar_id     = ar_idx;
    assign ar_addr       = slv.ar_addr;
    assign ar_user       = slv.ar_user;
    assign mst.ar_addr   = ar_addr;
    assign mst.ar_len    = slv.ar_len;
    assign mst.ar_size   = slv.ar_size;
    assign mst.ar_burst  = slv.ar_burst;
    assign mst.ar_lock   = slv.ar_lock;
    assign mst.ar_cache  = slv.ar_cache;
    assign mst.ar_prot   = slv.ar_prot;
    assign mst.ar_qos    = slv.ar_qos;
    assign mst.ar_region = slv.ar_region;
    assign mst.ar_user   = ar_user;

    assign r_data        = mst.r_data;
    assign slv.r_id      = r_orig_id;
    assign slv.r_data    = r_data;
    assign slv.r_resp    = mst.r_resp;
    assign slv.r_last    = mst.r_last;
    assign slv.r_user    = mst.r_user;
    assign slv.r_valid   = mst.r_valid;
    assign mst.r_ready   = slv.r_ready & mst.r_valid;

endmodule

// File: tb/tb_soc_node_id_remap.sv
// Directed bench for soc_node_id_remap: mapping, saturation, table-full,
// inc/dec collisions, interleaved read bursts and asynchronous reset.
module tb_soc_node_id_remap;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    AXI_BUS #(.AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(64), .AXI_ID_WIDTH(8), .AXI_USER_WIDTH(6)) slv_bus ();
    AXI_BUS #(.AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(64), .AXI_ID_WIDTH(4), .AXI_USER_WIDTH(6)) mst_bus ();

    soc_node_id_remap #(
        .AXI_AW(32), .AXI_DW(64), .AXI_UW(6),
        .AXI_IW_SLV(8), .AXI_IW_MST(4), .MAX_TXNS_PER_ID(4)
    ) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .slv   (slv_bus),
        .mst   (mst_bus)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        slv_bus.aw_id = '0; slv_bus.aw_addr = '0; slv_bus.aw_len = '0; slv_bus.aw_size = 3'd3;
        slv_bus.aw_burst = 2'b01; slv_bus.aw_lock = 1'b0; slv_bus.aw_cache = '0; slv_bus.aw_prot = '0;
        slv_bus.aw_qos = '0; slv_bus.aw_region = '0; slv_bus.aw_atop = '0; slv_bus.aw_user = '0;
        slv_bus.aw_valid = 1'b0;
        slv_bus.w_data = '0; slv_bus.w_strb = '1; slv_bus.w_last = 1'b0; slv_bus.w_user = '0;
        slv_bus.w_valid = 1'b0;
        slv_bus.ar_id = '0; slv_bus.ar_addr = '0; slv_bus.ar_len = '0; slv_bus.ar_size = 3'd3;
        slv_bus.ar_burst = 2'b01; slv_bus.ar_lock = 1'b0; slv_bus.ar_cache = '0; slv_bus.ar_prot = '0;
        slv_bus.ar_qos = '0; slv_bus.ar_region = '0; slv_bus.ar_user = '0; slv_bus.ar_valid = 1'b0;
        mst_bus.b_id = '0; mst_bus.b_resp = '0; mst_bus.b_user = '0; mst_bus.b_valid = 1'b0;
        mst_bus.r_id = '0; mst_bus.r_data = '0; mst_bus.r_resp = '0; mst_bus.r_last = 1'b0;
        mst_bus.r_user = '0; mst_bus.r_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive_idle();
        mst_bus.aw_ready = 1'b1; mst_bus.w_ready = 1'b1; mst_bus.ar_ready = 1'b1;
        slv_bus.b_ready = 1'b1; slv_bus.r_ready = 1'b1;
        #3;
        checks++;
        if ({mst_bus.aw_valid, mst_bus.w_valid, mst_bus.ar_valid} !== 3'b000) begin
            errors++; $display("FAIL reset_mst_valids actual=%b required=000",
                               {mst_bus.aw_valid, mst_bus.w_valid, mst_bus.ar_valid});
        end
        checks++;
        if ({slv_bus.b_valid, slv_bus.r_valid} !== 2'b00) begin
            errors++; $display("FAIL reset_slv_valids actual=%b required=00", {slv_bus.b_valid, slv_bus.r_valid});
        end
        checks++;
        if ({slv_bus.aw_ready, slv_bus.w_ready, slv_bus.ar_ready} !== 3'b000) begin
            errors++; $display("FAIL reset_slv_readies actual=%b required=000",
                               {slv_bus.aw_ready, slv_bus.w_ready, slv_bus.ar_ready});
        end
        checks++;
        if ({mst_bus.b_ready, mst_bus.r_ready} !== 2'b00) begin
            errors++; $display("FAIL reset_mst_readies actual=%b required=00", {mst_bus.b_ready, mst_bus.r_ready});
        end
        step(); step();
        rst_n = 1'b1;
        step();
        checks++;
        if ({mst_bus.aw_valid, mst_bus.ar_valid, slv_bus.aw_ready, slv_bus.ar_ready} !== 4'b0000) begin
            errors++; $display("FAIL post_reset_idle actual=%b required=0000",
                               {mst_bus.aw_valid, mst_bus.ar_valid, slv_bus.aw_ready, slv_bus.ar_ready});
        end
    endtask

    task automatic test_single_write();
        slv_bus.aw_valid = 1'b1; slv_bus.aw_id = 8'h23; slv_bus.aw_addr = 32'h1000_0040;
        slv_bus.aw_len = 8'd3; slv_bus.aw_user = 6'h2a;
        slv_bus.w_valid = 1'b1; slv_bus.w_data = 64'hDEAD_BEEF_0123_4567; slv_bus.w_last = 1'b1;
        #1;
        checks++;
        if ({mst_bus.aw_valid, slv_bus.aw_ready, mst_bus.aw_id} !== {2'b11, 4'h0}) begin
            errors++; $display("FAIL single_aw_map actual=%b/%b/%0h required=1/1/0",
                               mst_bus.aw_valid, slv_bus.aw_ready, mst_bus.aw_id);
        end
        checks++;
        if ({mst_bus.aw_addr, mst_bus.aw_len, mst_bus.aw_user} !== {32'h1000_0040, 8'd3, 6'h2a}) begin
            errors++; $display("FAIL single_aw_fields actual=%0h/%0h/%0h required=10000040/3/2a",
                               mst_bus.aw_addr, mst_bus.aw_len, mst_bus.aw_user);
        end
        checks++;
        if ({mst_bus.w_valid, slv_bus.w_ready, mst_bus.w_data} !== {2'b11, 64'hDEAD_BEEF_0123_4567}) begin
            errors++; $display("FAIL w_passthrough actual=%b/%b/%0h required=1/1/deadbeef01234567",
                               mst_bus.w_valid, slv_bus.w_ready, mst_bus.w_data);
        end
        step();
        slv_bus.w_valid = 1'b0;
        // B retiring entry 0 in the same cycle as a new miss: allocation must skip 0.
        mst_bus.b_valid = 1'b1; mst_bus.b_id = 4'h0; mst_bus.b_resp = 2'b10;
        slv_bus.aw_id = 8'h55;
        #1;
        checks++;
        if ({slv_bus.b_valid, slv_bus.b_id, slv_bus.b_resp} !== {1'b1, 8'h23, 2'b10}) begin
            errors++; $display("FAIL single_b_restore actual=%b/%0h/%0h required=1/23/2",
                               slv_bus.b_valid, slv_bus.b_id, slv_bus.b_resp);
        end
        checks++;
        if (mst_bus.aw_id !== 4'h1) begin
            errors++; $display("FAIL alloc_skips_draining actual=%0h required=1", mst_bus.aw_id);
        end
        step();
        mst_bus.b_valid = 1'b0;
        slv_bus.aw_id = 8'h66;
        #1;
        checks++;
        if (mst_bus.aw_id !== 4'h0) begin
            errors++; $display("FAIL entry0_freed actual=%0h required=0", mst_bus.aw_id);
        end
        step();
        slv_bus.aw_valid = 1'b0;
        mst_bus.b_valid = 1'b1; mst_bus.b_id = 4'h1; mst_bus.b_resp = 2'b00;
        #1;
        checks++;
        if (slv_bus.b_id !== 8'h55) begin
            errors++; $display("FAIL b_restore_idx1 actual=%0h required=55", slv_bus.b_id);
        end
        step();
        mst_bus.b_id = 4'h0;
        #1;
        checks++;
        if (slv_bus.b_id !== 8'h66) begin
            errors++; $display("FAIL b_restore_idx0 actual=%0h required=66", slv_bus.b_id);
        end
        step();
        mst_bus.b_valid = 1'b0;
    endtask

    task automatic test_inc_dec();
        slv_bus.aw_valid = 1'b1; slv_bus.aw_id = 8'h40;
        #1;
        checks++;
        if (mst_bus.aw_id !== 4'h0) begin
            errors++; $display("FAIL incdec_first actual=%0h required=0", mst_bus.aw_id);
        end
        step();
        mst_bus.b_valid = 1'b1; mst_bus.b_id = 4'h0;
        #1;
        checks++;
        if ({slv_bus.aw_ready, mst_bus.aw_id, slv_bus.b_id} !== {1'b1, 4'h0, 8'h40}) begin
            errors++; $display("FAIL incdec_collide actual=%b/%0h/%0h required=1/0/40",
                               slv_bus.aw_ready, mst_bus.aw_id, slv_bus.b_id);
        end
        step();
        mst_bus.b_valid = 1'b0;
        mst_bus.aw_ready = 1'b0; slv_bus.aw_id = 8'h41;
        #1;
        checks++;
        if (mst_bus.aw_id !== 4'h1) begin
            errors++; $display("FAIL incdec_entry_kept actual=%0h required=1", mst_bus.aw_id);
        end
        slv_bus.aw_valid = 1'b0; mst_bus.aw_ready = 1'b1;
        mst_bus.b_valid = 1'b1; mst_bus.b_id = 4'h0;
        #1;
        checks++;
        if (slv_bus.b_id !== 8'h40) begin
            errors++; $display("FAIL incdec_orig_kept actual=%0h required=40", slv_bus.b_id);
        end
        step();
        mst_bus.b_valid = 1'b0;
        slv_bus.aw_valid = 1'b1; slv_bus.aw_id = 8'h77;
        #1;
        checks++;
        if (mst_bus.aw_id !== 4'h0) begin
            errors++; $display("FAIL incdec_cnt_was_one actual=%0h required=0", mst_bus.aw_id);
        end
        step();
        slv_bus.aw_valid = 1'b0;
        mst_bus.b_valid = 1'b1; mst_bus.b_id = 4'h0;
        step();
        mst_bus.b_valid = 1'b0;
    endtask

    task automatic test_saturation();
        slv_bus.ar_valid = 1'b1; slv_bus.ar_id = 8'h11; slv_bus.ar_addr = 32'h2000_0000;
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++;
            if ({slv_bus.ar_ready, mst_bus.ar_id} !== {1'b1, 4'h0}) begin
                errors++; $display("FAIL sat_accept_%0d actual=%b/%0h required=1/0", k, slv_bus.ar_ready, mst_bus.ar_id);
            end
            step();
        end
        checks++;
        if ({slv_bus.ar_ready, mst_bus.ar_valid} !== 2'b00) begin
            errors++; $display("FAIL sat_stall actual=%b required=00", {slv_bus.ar_ready, mst_bus.ar_valid});
        end
        step();
        mst_bus.r_valid = 1'b1; mst_bus.r_id = 4'h0; mst_bus.r_last = 1'b1; mst_bus.r_data = 64'h1111;
        #1;
        checks++;
        if ({slv_bus.r_id, slv_bus.r_data, slv_bus.ar_ready} !== {8'h11, 64'h1111, 1'b0}) begin
            errors++; $display("FAIL sat_rlast_cycle actual=%0h/%0h/%b required=11/1111/0",
                               slv_bus.r_id, slv_bus.r_data, slv_bus.ar_ready);
        end
        step();
        mst_bus.r_valid = 1'b0;
        #1;
        checks++;
        if ({slv_bus.ar_ready, mst_bus.ar_id} !== {1'b1, 4'h0}) begin
            errors++; $display("FAIL sat_resume actual=%b/%0h required=1/0", slv_bus.ar_ready, mst_bus.ar_id);
        end
        step();
        slv_bus.ar_valid = 1'b0;
        mst_bus.r_valid = 1'b1;
        for (int k = 0; k < 4; k++) step();
        mst_bus.r_valid = 1'b0;
    endtask

    task automatic test_table_full();
        slv_bus.ar_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            slv_bus.ar_id = 8'(i);
            #1;
            checks++;
            if ({slv_bus.ar_ready, mst_bus.ar_id} !== {1'b1, 4'(i)}) begin
                errors++; $display("FAIL full_fill_%0d actual=%b/%0h required=1/%0h", i, slv_bus.ar_ready, mst_bus.ar_id, i);
            end
            step();
        end
        slv_bus.ar_id = 8'h80;
        #1;
        checks++;
        if ({slv_bus.ar_ready, mst_bus.ar_valid} !== 2'b00) begin
            errors++; $display("FAIL full_stall actual=%b required=00", {slv_bus.ar_ready, mst_bus.ar_valid});
        end
        mst_bus.r_valid = 1'b1; mst_bus.r_id = 4'h5; mst_bus.r_last = 1'b1;
        #1;
        checks++;
        if ({slv_bus.r_id, slv_bus.ar_ready} !== {8'h05, 1'b0}) begin
            errors++; $display("FAIL full_free5 actual=%0h/%b required=5/0", slv_bus.r_id, slv_bus.ar_ready);
        end
        step();
        mst_bus.r_valid = 1'b0;
        #1;
        checks++;
        if ({slv_bus.ar_ready, mst_bus.ar_id} !== {1'b1, 4'h5}) begin
            errors++; $display("FAIL full_realloc5 actual=%b/%0h required=1/5", slv_bus.ar_ready, mst_bus.ar_id);
        end
        step();
        slv_bus.ar_valid = 1'b0;
        mst_bus.r_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            mst_bus.r_id = 4'(i);
            #1;
            checks++;
            if (slv_bus.r_id !== ((i == 5) ? 8'h80 : 8'(i))) begin
                errors++; $display("FAIL full_drain_%0d actual=%0h required=%0h", i, slv_bus.r_id,
                                   (i == 5) ? 8'h80 : 8'(i));
            end
            step();
        end
        mst_bus.r_valid = 1'b0;
    endtask

    task automatic test_interleaved();
        int unsigned seq_idx [8];
        logic        seq_last [8];
        seq_idx  = '{0, 1, 1, 0, 0, 1, 0, 1};
        seq_last = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        slv_bus.ar_valid = 1'b1; slv_bus.ar_id = 8'h01;
        #1;
        checks++;
        if (mst_bus.ar_id !== 4'h0) begin
            errors++; $display("FAIL ilv_ar01 actual=%0h required=0", mst_bus.ar_id);
        end
        step();
        slv_bus.ar_id = 8'h02;
        #1;
        checks++;
        if (mst_bus.ar_id !== 4'h1) begin
            errors++; $display("FAIL ilv_ar02 actual=%0h required=1", mst_bus.ar_id);
        end
        step();
        // Park a non-handshaking probe AR to watch which entries are still held.
        mst_bus.ar_ready = 1'b0; slv_bus.ar_id = 8'h03;
        for (int j = 0; j < 8; j++) begin
            mst_bus.r_valid = 1'b1; mst_bus.r_id = 4'(seq_idx[j]); mst_bus.r_last = seq_last[j];
            mst_bus.r_data = 64'(j);
            #1;
            checks++;
            if ({slv_bus.r_id, slv_bus.r_data} !== {((seq_idx[j] == 1) ? 8'h02 : 8'h01), 64'(j)}) begin
                errors++; $display("FAIL ilv_beat_%0d actual=%0h/%0h required=%0h/%0h", j, slv_bus.r_id,
                                   slv_bus.r_data, (seq_idx[j] == 1) ? 8'h02 : 8'h01, j);
            end
            checks++;
            if (mst_bus.ar_id !== ((j == 7) ? 4'h0 : 4'h2)) begin
                errors++; $display("FAIL ilv_hold_%0d actual=%0h required=%0h", j, mst_bus.ar_id,
                                   (j == 7) ? 4'h0 : 4'h2);
            end
            step();
        end
        mst_bus.r_valid = 1'b0; mst_bus.r_last = 1'b0;
        mst_bus.ar_ready = 1'b1;
        #1;
        checks++;
        if (mst_bus.ar_id !== 4'h0) begin
            errors++; $display("FAIL ilv_free0 actual=%0h required=0", mst_bus.ar_id);
        end
        step();
        mst_bus.ar_ready = 1'b0; slv_bus.ar_id = 8'h06;
        #1;
        checks++;
        if (mst_bus.ar_id !== 4'h1) begin
            errors++; $display("FAIL ilv_free1 actual=%0h required=1", mst_bus.ar_id);
        end
        slv_bus.ar_valid = 1'b0; mst_bus.ar_ready = 1'b1;
        mst_bus.r_valid = 1'b1; mst_bus.r_id = 4'h0; mst_bus.r_last = 1'b1;
        step();
        mst_bus.r_valid = 1'b0;
    endtask

    task automatic test_async_reset();
        slv_bus.aw_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            slv_bus.aw_id = 8'h31 + 8'(i);
            #1;
            checks++;
            if (mst_bus.aw_id !== 4'(i)) begin
                errors++; $display("FAIL arst_fill_%0d actual=%0h required=%0h", i, mst_bus.aw_id, i);
            end
            step();
        end
        mst_bus.aw_ready = 1'b0; slv_bus.aw_id = 8'h33;
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (mst_bus.aw_id !== 4'h0) begin
            errors++; $display("FAIL arst_immediate actual=%0h required=0", mst_bus.aw_id);
        end
        step();
        rst_n = 1'b1;
        mst_bus.aw_ready = 1'b1; slv_bus.aw_id = 8'h99;
        #1;
        checks++;
        if ({slv_bus.aw_ready, mst_bus.aw_id} !== {1'b1, 4'h0}) begin
            errors++; $display("FAIL arst_first_aw actual=%b/%0h required=1/0", slv_bus.aw_ready, mst_bus.aw_id);
        end
        step();
        mst_bus.aw_ready = 1'b0; slv_bus.aw_id = 8'h31;
        #1;
        checks++;
        if (mst_bus.aw_id !== 4'h1) begin
            errors++; $display("FAIL arst_second_aw actual=%0h required=1", mst_bus.aw_id);
        end
        slv_bus.aw_valid = 1'b0; mst_bus.aw_ready = 1'b1;
        step();
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_inc_dec();
        test_saturation();
        test_table_full();
        test_interleaved();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
